// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared FSM encoding and chunk-count helpers for the add/sub engine
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_if.sv
// rtl/addsub_if.sv - operand/result handshake bundle for the add/sub engine
interface addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero, neg
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational CHUNK-bit adder slice with carry in/out
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/addsub_seq.sv
// rtl/addsub_seq.sv - multi-cycle add/sub engine, one CHUNK per cycle, LSB chunk first
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    addsub_if.slave bus
);

    localparam int            NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int            CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST   = CW'(NCHUNK - 1);

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nx;
    logic             carry;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             neg_q;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK-1:0] s_ch;
    logic             co_ch;
    logic             last;

    assign last = (cnt == LAST);

    always_comb begin
        a_ch = a_q[int'(cnt) * CHUNK +: CHUNK];
        b_ch = b_q[int'(cnt) * CHUNK +: CHUNK];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x  (a_ch),
        .y  (b_ch),
        .ci (carry),
        .s  (s_ch),
        .co (co_ch)
    );

    // Full sum as it will look after this chunk; flags on the last chunk read it.
    always_comb begin
        sum_nx = sum_q;
        sum_nx[int'(cnt) * CHUNK +: CHUNK] = s_ch;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = RUN;
            RUN:     if (last)         state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Subtraction is A + ~B + ~borrow, so B and the carry are inverted at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub ? ~bus.cin : bus.cin;
                        cnt   <= '0;
                        sum_q <= '0;
                    end
                end
                RUN: begin
                    sum_q <= sum_nx;
                    carry <= co_ch;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout_q <= co_ch;
                        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_nx[WIDTH-1] != a_q[WIDTH-1]);
                        zero_q <= ~|sum_nx;
                        neg_q  <= sum_nx[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;

endmodule
